// File: rtl/cache_types_pkg.sv
// Shared types for the L1 cache controller: FSM states, address split, mux selects.
package cache_types_pkg;

  localparam int TAG_W = 24;
  localparam int IDX_W = 3;
  localparam int OFF_W = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  typedef enum logic {
    PADDR_REQ    = 1'b0,
    PADDR_VICTIM = 1'b1
  } paddr_sel_t;

  typedef enum logic {
    DSEL_PMEM = 1'b0,
    DSEL_CPU  = 1'b1
  } data_sel_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } addr_t;

  function automatic addr_t split_addr(input logic [31:0] a);
    return addr_t'(a);
  endfunction

endpackage

// File: rtl/cache_control.sv
// Control FSM for the direct-mapped, write-back, write-allocate L1 cache.
module cache_control
  import cache_types_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      mem_address,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic             pmem_addr_sel,
  input  logic [TAG_W-1:0] tag_out,
  input  logic             valid_out,
  input  logic             dirty_out,
  output logic [IDX_W-1:0] arr_index,
  output logic             load_tag,
  output logic             load_valid,
  output logic             valid_in,
  output logic             load_dirty,
  output logic             dirty_in,
  output logic             load_data,
  output logic             data_sel,
  output logic             hit
);

  state_t state, state_nxt;
  logic   tag_match;

  // Index follows the CPU address in every state; the CPU holds it for the whole miss.
  assign arr_index = split_addr(mem_address).index;
  assign tag_match = valid_out && (tag_out == split_addr(mem_address).tag);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (mem_read || mem_write) state_nxt = COMPARE;
      COMPARE: begin
        if (tag_match)                   state_nxt = IDLE;
        else if (valid_out && dirty_out) state_nxt = WRITEBACK;
        else                             state_nxt = ALLOCATE;
      end
      WRITEBACK: if (pmem_resp) state_nxt = ALLOCATE;
      ALLOCATE:  if (pmem_resp) state_nxt = COMPARE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Gated by rst so pmem requests drop in the same cycle reset is raised.
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = PADDR_REQ;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    valid_in      = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    load_data     = 1'b0;
    data_sel      = DSEL_PMEM;
    hit           = 1'b0;
    if (!rst) begin
      case (state)
        COMPARE: begin
          hit = tag_match;
          if (tag_match) begin
            mem_resp = 1'b1;
            // A simultaneous read+write is handled as a write.
            if (mem_write) begin
              load_data  = 1'b1;
              data_sel   = DSEL_CPU;
              load_dirty = 1'b1;
              dirty_in   = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = PADDR_VICTIM;
          if (pmem_resp) begin
            load_dirty = 1'b1;
            dirty_in   = 1'b0;
          end
        end
        ALLOCATE: begin
          pmem_read     = 1'b1;
          pmem_addr_sel = PADDR_REQ;
          if (pmem_resp) begin
            load_data  = 1'b1;
            data_sel   = DSEL_PMEM;
            load_tag   = 1'b1;
            load_valid = 1'b1;
            valid_in   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write));

  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |-> (mem_read || mem_write));

  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    ((state != IDLE) && !mem_resp) |=> $stable(mem_address));

endmodule

// File: tb/tb_cache_control.sv
// Randomized scoreboard bench for cache_control with behavioural array and cache models.
module tb_cache_control;
  import cache_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0]      mem_address = '0;
  logic             mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic             pmem_resp = 1'b0;
  logic [TAG_W-1:0] tag_out;
  logic             valid_out, dirty_out;
  logic [IDX_W-1:0] arr_index;
  logic             load_tag, load_valid, valid_in, load_dirty, dirty_in, load_data, data_sel, hit;

  cache_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel),
    .tag_out(tag_out), .valid_out(valid_out), .dirty_out(dirty_out),
    .arr_index(arr_index), .load_tag(load_tag), .load_valid(load_valid),
    .valid_in(valid_in), .load_dirty(load_dirty), .dirty_in(dirty_in),
    .load_data(load_data), .data_sel(data_sel), .hit(hit)
  );

  // Tag/valid/dirty arrays the controller drives; reset with rst like the real arrays.
  logic [TAG_W-1:0] a_tag [8];
  logic [7:0]       a_valid, a_dirty;
  always @(posedge clk) begin
    if (rst) begin
      a_valid <= '0;
      a_dirty <= '0;
      for (int i = 0; i < 8; i++) a_tag[i] <= '0;
    end else begin
      if (load_tag)   a_tag[arr_index]   <= mem_address[31:8];
      if (load_valid) a_valid[arr_index] <= valid_in;
      if (load_dirty) a_dirty[arr_index] <= dirty_in;
    end
  end
  assign tag_out   = a_tag[arr_index];
  assign valid_out = a_valid[arr_index];
  assign dirty_out = a_dirty[arr_index];

  // Reference cache state: which line each set holds and whether it is modified.
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [23:0] m_tag   [8];

  localparam int EV_WB = 0, EV_FILL = 1, EV_RESP = 2;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    bit          wr;
    bit          hit;
    int          start;
  } exp_t;
  exp_t expq[$];

  int  cyc = 0;
  int  nerr = 0, nchk = 0;
  bit  done = 1'b0;
  bit  resp_en = 1'b1;
  bit  spur = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory responder: pulses pmem_resp after a (randomized) number of request cycles.
  initial begin
    int cnt = 0;
    int dly = 5;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) pmem_resp = 1'b0;
      else if (spur) begin pmem_resp = 1'b1; spur = 1'b0; end
      else if (resp_en && !rst && (pmem_read || pmem_write)) begin
        cnt++;
        if (cnt >= dly) begin
          pmem_resp = 1'b1;
          cnt = 0;
          dly = $urandom_range(1, 6);
        end
      end else cnt = 0;
    end
  end

  // Monitor: sole owner of the check counters; pops the expectation queue on every DUT event.
  initial begin
    bit   prev_pr = 0, prev_pw = 0, prev_rr = 0, prev_rw = 0;
    int   stall = 0;
    bit   ev;
    exp_t e;
    logic [11:0] outs;
    logic [31:0] paddr;
    forever begin
      @(negedge clk);
      cyc++;
      ev = 1'b0;
      outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_tag, load_valid,
              valid_in, load_dirty, dirty_in, load_data, data_sel, hit};
      paddr = {(pmem_addr_sel ? tag_out : mem_address[31:8]), arr_index, 5'b0};
      if (rst) check(outs == 12'h0, "reset_outputs", 32'(outs), 32'h0);
      else begin
        if (!mem_read && !mem_write) check(outs == 12'h0, "idle_outputs", 32'(outs), 32'h0);
        if (pmem_read || pmem_write)
          check(!(pmem_read && pmem_write), "pmem_exclusive", {pmem_read, pmem_write}, 32'h0);
        if (prev_rw) check(!pmem_write, "pmem_write_drop", 32'(pmem_write), 32'h0);
        if (prev_rr) check(!pmem_read, "pmem_read_drop", 32'(pmem_read), 32'h0);
        if (pmem_write && !prev_pw) begin
          ev = 1'b1;
          if (expq.size() == 0) check(1'b0, "unexpected_writeback", paddr, 32'h0);
          else begin
            e = expq.pop_front();
            check(e.kind == EV_WB, "writeback_order", 32'(EV_WB), 32'(e.kind));
            check(paddr == e.addr, "writeback_addr", paddr, e.addr);
          end
        end
        if (pmem_read && !prev_pr) begin
          ev = 1'b1;
          if (expq.size() == 0) check(1'b0, "unexpected_fill", paddr, 32'h0);
          else begin
            e = expq.pop_front();
            check(e.kind == EV_FILL, "fill_order", 32'(EV_FILL), 32'(e.kind));
            check(paddr == e.addr && !pmem_addr_sel, "fill_addr", paddr, e.addr);
          end
        end
        if (pmem_resp && pmem_write)
          check({load_dirty, dirty_in, load_data, load_tag, load_valid} == 5'b10000,
                "writeback_done_loads", {load_dirty, dirty_in, load_data, load_tag, load_valid}, 32'b10000);
        if (pmem_resp && pmem_read)
          check({load_data, data_sel, load_tag, load_valid, valid_in, load_dirty} == 6'b101110,
                "fill_done_loads", {load_data, data_sel, load_tag, load_valid, valid_in, load_dirty}, 32'b101110);
        if (pmem_resp && !pmem_read && !pmem_write)
          check({mem_resp, load_tag, load_valid, load_dirty, load_data} == 5'b0,
                "spurious_resp", {mem_resp, load_tag, load_valid, load_dirty, load_data}, 32'h0);
        if (mem_resp) begin
          ev = 1'b1;
          if (expq.size() == 0) check(1'b0, "unexpected_mem_resp", 32'(mem_resp), 32'h0);
          else begin
            e = expq.pop_front();
            check(e.kind == EV_RESP, "resp_order", 32'(EV_RESP), 32'(e.kind));
            check(hit, "hit_on_resp", 32'(hit), 32'h1);
            if (e.hit) check(cyc - e.start == 2, "hit_latency", 32'(cyc - e.start), 32'd2);
            else       check(cyc - e.start > 2, "miss_latency", 32'(cyc - e.start), 32'd3);
            check({load_data, data_sel, load_dirty, dirty_in, load_tag, load_valid} ==
                  (e.wr ? 6'b111100 : 6'b000000), "resp_loads",
                  {load_data, data_sel, load_dirty, dirty_in, load_tag, load_valid},
                  (e.wr ? 32'b111100 : 32'b0));
          end
        end
      end
      prev_pr = pmem_read;
      prev_pw = pmem_write;
      prev_rr = pmem_resp && pmem_read;
      prev_rw = pmem_resp && pmem_write;
      if (expq.size() != 0 && !ev) stall++;
      else stall = 0;
      if (stall > 300) begin
        check(1'b0, "event_timeout", 32'(expq.size()), 32'h0);
        expq.delete();
        stall = 0;
      end
      if (done || cyc > 60000) begin
        check(!done || expq.size() == 0, "scoreboard_drained", 32'(expq.size()), 32'h0);
        check(done, "global_timeout", 32'(cyc), 32'd60000);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
    end
  endtask

  // Push the expected event sequence for one request, then assert it.
  task automatic issue(input logic [31:0] addr, input bit wr);
    exp_t e;
    int   s = int'(addr[7:5]);
    bit   h = m_valid[s] && (m_tag[s] == addr[31:8]);
    if (!h) begin
      if (m_valid[s] && m_dirty[s]) begin
        e = '{kind: EV_WB, addr: {m_tag[s], addr[7:5], 5'b0}, wr: 0, hit: 0, start: 0};
        expq.push_back(e);
      end
      e = '{kind: EV_FILL, addr: {addr[31:5], 5'b0}, wr: 0, hit: 0, start: 0};
      expq.push_back(e);
      m_valid[s] = 1;
      m_tag[s]   = addr[31:8];
      m_dirty[s] = 0;
    end
    if (wr) m_dirty[s] = 1;
    e = '{kind: EV_RESP, addr: addr, wr: wr, hit: h, start: cyc};
    expq.push_back(e);
    mem_address = addr;
    mem_read    = !wr;
    mem_write   = wr;
  endtask

  task automatic do_req(input logic [31:0] addr, input bit wr);
    issue(addr, wr);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem_resp) break;
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [23:0] tags [4];
    tags[0] = 24'h000000; tags[1] = 24'h000010; tags[2] = 24'hABCDEF; tags[3] = 24'h000001;
    model_reset();
    // Request held during reset must not produce any output.
    mem_read = 1'b1; mem_address = 32'h0000_0040;
    repeat (3) begin @(posedge clk); #1; end
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    do_req(32'h0000_0040, 1'b0);   // cold miss, fill, re-compare hit
    do_req(32'h0000_0040, 1'b0);   // hit, 2-cycle latency
    do_req(32'h0000_0044, 1'b1);   // write hit, marks line dirty
    do_req(32'h0000_1040, 1'b0);   // dirty conflict: writeback then fill

    // Reset while a fill is outstanding.
    resp_en = 1'b0;
    issue(32'h0000_2060, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pmem_read) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    mem_read = 1'b0;
    expq.delete();
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    resp_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    do_req(32'h0000_2060, 1'b0);

    // Spurious memory response while idle.
    spur = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      do_req(a, 1'($urandom_range(0, 1)));
    end

    repeat (3) begin @(posedge clk); #1; end
    done = 1'b1;
  end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control FSM for the direct-mapped, 8-set, write-back, write-allocate L1 cache.
- Sits between the CPU memory port and the physical-memory port.
- Drives load/index/data-in for the 8-entry valid, dirty, tag and data arrays; consumes their read outputs to decide hit/miss.
- Owns hit detection, victim writeback sequencing and line allocation; it holds no data itself.

Parameters:
- TAG_W, 24, tag width; address = {tag, index[2:0], offset[4:0]}.
- IDX_W, 3, set index width (8 sets, matches array depth).
- OFF_W, 5, byte offset within a 256-bit line.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  32  CPU address, stable while request held
- mem_resp  out  1  one-cycle completion pulse to CPU
- pmem_read  out  1  line-fill request to memory
- pmem_write  out  1  victim writeback request to memory
- pmem_resp  in  1  one-cycle memory completion pulse
- pmem_addr_sel  out  1  0: {req tag, index, 0}; 1: {stored tag, index, 0}
- tag_out  in  TAG_W  tag array read data
- valid_out  in  1  valid array read data
- dirty_out  in  1  dirty array read data
- arr_index  out  IDX_W  rindex/windex to all arrays = mem_address[7:5]
- load_tag  out  1  tag array write enable
- load_valid  out  1  valid array write enable
- valid_in  out  1  valid array write data
- load_dirty  out  1  dirty array write enable
- dirty_in  out  1  dirty array write data
- load_data  out  1  data array write enable
- data_sel  out  1  0: line from pmem; 1: CPU write-merge
- hit  out  1  combinational hit, for perf counters

Behaviour:
- hit = valid_out & (tag_out == mem_address[31:8]); evaluated only in COMPARE.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. Reset → IDLE. All outputs are 0 in IDLE and during reset.
- IDLE: if mem_read|mem_write → COMPARE next cycle; else stay.
- COMPARE:
  - hit & read: mem_resp=1 → IDLE.
  - hit & write: load_data=1, data_sel=1, load_dirty=1, dirty_in=1, mem_resp=1 → IDLE.
  - miss & valid_out & dirty_out → WRITEBACK.
  - miss otherwise → ALLOCATE.
- Hit latency: 2 cycles from request assertion to mem_resp (IDLE + COMPARE).
- WRITEBACK: pmem_write=1, pmem_addr_sel=1, held until pmem_resp. On pmem_resp: load_dirty=1, dirty_in=0 → ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_addr_sel=0, held until pmem_resp. On pmem_resp: load_data=1, data_sel=0, load_tag=1, load_valid=1, valid_in=1 → COMPARE.
  - The array forwards same-cycle writes (rindex==windex), so the re-compare sees the new line next cycle and hits.
- pmem_read and pmem_write are never both 1; each is deasserted in the cycle after pmem_resp.
- mem_resp is exactly one cycle per request, never issued outside COMPARE.
- Simultaneous mem_read & mem_write: protocol violation; treat as write; assertion flags it.
- pmem_resp outside WRITEBACK/ALLOCATE: ignored.
- rst mid-miss: FSM → IDLE the next edge; pmem requests drop immediately. Array contents are reset by the arrays themselves.
- Requests dropped by the CPU before mem_resp: undefined; covered by assertion only.
- arr_index is driven from mem_address in every state; it must not change during a miss (CPU holds address).

Decomposition:
- Package cache_types_pkg: state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE), TAG_W/IDX_W/OFF_W localparams, address-field extraction functions, pmem_addr_sel and data_sel enums.
- No sub-module: FSM next-state and output logic are two always_comb blocks plus one state flop; hit compare is inline.

Test Plan:
- Reset, then read 0x0000_0040 on cold cache → ALLOCATE, pmem_read with addr sel 0; pmem_resp after 5 cycles → load_tag/valid/data pulse, COMPARE hit, mem_resp one cycle later; no pmem_write seen.
- Repeat read 0x0000_0040 → mem_resp exactly 2 cycles after request, no pmem activity.
- Write 0x0000_0044 (hit) → load_data with data_sel=1, load_dirty with dirty_in=1, mem_resp in the same cycle.
- Read 0x0000_1040 (same index 2, new tag, line dirty) → WRITEBACK with pmem_addr_sel=1 until pmem_resp, dirty cleared, ALLOCATE fill, then hit and mem_resp; pmem_write strictly precedes pmem_read.
- Assert rst during ALLOCATE with pmem_read high → pmem_read low and state IDLE after the edge; the next read of the same set misses cleanly.
- Spurious pmem_resp in IDLE → no state change, no array loads, no mem_resp.
